// File: rtl/ps2_scancode_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_scancode_decoder_if
// Brief    : Byte-in / key-event-out bundle for the PS/2 scan-code decoder.
// Revision : 1.0  initial release
// ============================================================================
interface ps2_scancode_decoder_if;
   logic [7:0] iData;
   logic       iValid;
   logic       iRead;
   logic       oValid;
   logic [7:0] oKeyCode;
   logic       oBreak;
   logic       oExtended;
   logic [7:0] oAscii;
   logic       oShift;
   logic       oError;
   logic       oOverflow;

   modport master (
      output iData, iValid, iRead,
      input  oValid, oKeyCode, oBreak, oExtended, oAscii, oShift, oError, oOverflow
   );

   modport slave (
      input  iData, iValid, iRead,
      output oValid, oKeyCode, oBreak, oExtended, oAscii, oShift, oError, oOverflow
   );
endinterface
`default_nettype wire

// File: rtl/ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_scancode_decoder
// Brief    : Tracks E0/F0 prefixes, emits key events into a FWFT event FIFO.
// Revision : 1.0  initial release
// ============================================================================
module ps2_scancode_decoder #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 2
) (
   input  wire                  Clock,
   input  wire                  Reset,
   ps2_scancode_decoder_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_GOT_E0   = 2'd1,
      ST_GOT_F0   = 2'd2,
      ST_GOT_E0F0 = 2'd3
   } state_t;

   typedef struct packed {
      logic [7:0] code;
      logic       brk;
      logic       ext;
      logic [7:0] ascii;
   } event_t;

   localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(FIFO_DEPTH);
   localparam logic [7:0]      c_e0    = 8'hE0;
   localparam logic [7:0]      c_f0    = 8'hF0;

   state_t            r_state, w_state_nxt;
   logic              w_emit, w_ext, w_brk, w_err;
   logic              r_lshift, r_rshift, r_error, r_overflow;
   logic              w_shift;
   event_t            w_event;
   event_t            r_mem [FIFO_DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              w_full, w_nonempty, w_pop, w_push;

   function automatic logic [7:0] map_ascii(input logic [7:0] code, input logic shift);
      logic [7:0] a;
      a = 8'h00;
      case (code)
         8'h45: a = 8'h30;
         8'h16: a = 8'h31;
         8'h1E: a = 8'h32;
         8'h26: a = 8'h33;
         8'h25: a = 8'h34;
         8'h2E: a = 8'h35;
         8'h36: a = 8'h36;
         8'h3D: a = 8'h37;
         8'h3E: a = 8'h38;
         8'h46: a = 8'h39;
         8'h1C: a = shift ? 8'h41 : 8'h61;
         8'h32: a = shift ? 8'h42 : 8'h62;
         8'h21: a = shift ? 8'h43 : 8'h63;
         8'h23: a = shift ? 8'h44 : 8'h64;
         8'h24: a = shift ? 8'h45 : 8'h65;
         8'h2B: a = shift ? 8'h46 : 8'h66;
         8'h5A: a = 8'h0D;
         8'h29: a = 8'h20;
         8'h66: a = 8'h08;
         default: a = 8'h00;
      endcase
      return a;
   endfunction

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_emit      = 1'b0;
      w_ext       = 1'b0;
      w_brk       = 1'b0;
      w_err       = 1'b0;
      if (bus.iValid) begin
         case (r_state)
            ST_IDLE: begin
               if (bus.iData == c_e0)      w_state_nxt = ST_GOT_E0;
               else if (bus.iData == c_f0) w_state_nxt = ST_GOT_F0;
               else if (bus.iData != 8'hAA && bus.iData != 8'hFA && bus.iData != 8'hEE)
                  w_emit = 1'b1;
            end
            ST_GOT_E0: begin
               if (bus.iData == c_f0)      w_state_nxt = ST_GOT_E0F0;
               else if (bus.iData != c_e0) begin
                  w_emit      = 1'b1;
                  w_ext       = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_GOT_F0: begin
               w_state_nxt = ST_IDLE;
               if (bus.iData == c_e0 || bus.iData == c_f0) w_err = 1'b1;
               else begin
                  w_emit = 1'b1;
                  w_brk  = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               if (bus.iData == c_e0 || bus.iData == c_f0) w_err = 1'b1;
               else begin
                  w_emit = 1'b1;
                  w_ext  = 1'b1;
                  w_brk  = 1'b1;
               end
            end
         endcase
      end
   end

   // ASCII is looked up with the shift state held before this edge
   assign w_shift       = r_lshift | r_rshift;
   assign w_event.code  = bus.iData;
   assign w_event.brk   = w_brk;
   assign w_event.ext   = w_ext;
   assign w_event.ascii = w_ext ? 8'h00 : map_ascii(bus.iData, w_shift);

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_lshift <= 1'b0;
         r_rshift <= 1'b0;
         r_error  <= 1'b0;
      end else begin
         r_error <= w_err;
         if (w_emit && !w_ext) begin
            if (bus.iData == 8'h12) r_lshift <= !w_brk;
            if (bus.iData == 8'h59) r_rshift <= !w_brk;
         end
      end
   end

   assign w_nonempty = (r_count != '0);
   assign w_full     = (r_count == c_depth);
   assign w_pop      = bus.iRead && w_nonempty;
   // A full FIFO still accepts a write when the head leaves on the same edge
   assign w_push     = w_emit && (!w_full || w_pop);

   always_ff @(posedge Clock) begin
      if (w_push) r_mem[r_wr_ptr] <= w_event;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_emit && !w_push) r_overflow <= 1'b1;
      end
   end

   assign bus.oValid    = w_nonempty;
   assign bus.oKeyCode  = w_nonempty ? r_mem[r_rd_ptr].code  : 8'h00;
   assign bus.oBreak    = w_nonempty ? r_mem[r_rd_ptr].brk   : 1'b0;
   assign bus.oExtended = w_nonempty ? r_mem[r_rd_ptr].ext   : 1'b0;
   assign bus.oAscii    = w_nonempty ? r_mem[r_rd_ptr].ascii : 8'h00;
   assign bus.oShift    = w_shift;
   assign bus.oError    = r_error;
   assign bus.oOverflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_scancode_decoder
// Brief    : Table-driven, scoreboarded bench for ps2_scancode_decoder.
// Revision : 1.0  initial release
// ============================================================================
module tb_ps2_scancode_decoder;

   typedef struct {
      logic [7:0] d;
      bit         ev;
      logic [7:0] code;
      bit         brk;
      bit         ext;
      logic [7:0] asc;
      bit         sh;
   } vec_t;

   typedef struct {
      logic [7:0] code;
      bit         brk;
      bit         ext;
      logic [7:0] asc;
   } ev_t;

   logic   Clock = 1'b0;
   logic   Reset = 1'b0;
   int     n_checks = 0;
   int     n_fail   = 0;
   vec_t   tbl[$];
   ev_t    exp_q[$];

   ps2_scancode_decoder_if bus ();

   ps2_scancode_decoder #(.FIFO_DEPTH(4), .ADDR_W(2)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   always #5 Clock = ~Clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [7:0] d, input bit ev, input logic [7:0] code,
                      input bit brk, input bit ext, input logic [7:0] asc, input bit sh);
      vec_t v;
      v.d = d; v.ev = ev; v.code = code; v.brk = brk; v.ext = ext; v.asc = asc; v.sh = sh;
      tbl.push_back(v);
   endtask

   task automatic expect_ev(input logic [7:0] code, input bit brk, input bit ext, input logic [7:0] asc);
      ev_t e;
      e.code = code; e.brk = brk; e.ext = ext; e.asc = asc;
      exp_q.push_back(e);
   endtask

   // Returns at the falling edge right after the edge that sampled the byte
   task automatic strobe(input logic [7:0] d, input logic rd);
      @(negedge Clock);
      bus.iData  = d;
      bus.iValid = 1'b1;
      bus.iRead  = rd;
      @(negedge Clock);
      bus.iValid = 1'b0;
      bus.iRead  = 1'b0;
   endtask

   task automatic drain();
      ev_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("valid", 32'(bus.oValid), 32'd1);
         check("keycode", 32'(bus.oKeyCode), 32'(e.code));
         check("break", 32'(bus.oBreak), 32'(e.brk));
         check("extended", 32'(bus.oExtended), 32'(e.ext));
         check("ascii", 32'(bus.oAscii), 32'(e.asc));
         bus.iRead = 1'b1;
         @(negedge Clock);
         bus.iRead = 1'b0;
      end
      check("empty_after_drain", 32'(bus.oValid), 32'd0);
      check("fields_zero_when_empty",
            32'({bus.oKeyCode, bus.oBreak, bus.oExtended, bus.oAscii}), 32'd0);
   endtask

   initial begin
      bus.iData  = 8'h00;
      bus.iValid = 1'b0;
      bus.iRead  = 1'b0;

      add(8'h16, 1, 8'h16, 0, 0, 8'h31, 0);
      add(8'hF0, 0, 8'h00, 0, 0, 8'h00, 0);
      add(8'h1C, 1, 8'h1C, 1, 0, 8'h61, 0);
      add(8'h12, 1, 8'h12, 0, 0, 8'h00, 1);
      add(8'h23, 1, 8'h23, 0, 0, 8'h44, 1);
      add(8'hF0, 0, 8'h00, 0, 0, 8'h00, 1);
      add(8'h12, 1, 8'h12, 1, 0, 8'h00, 0);
      add(8'h23, 1, 8'h23, 0, 0, 8'h64, 0);
      add(8'hE0, 0, 8'h00, 0, 0, 8'h00, 0);
      add(8'h75, 1, 8'h75, 0, 1, 8'h00, 0);
      add(8'hE0, 0, 8'h00, 0, 0, 8'h00, 0);
      add(8'hF0, 0, 8'h00, 0, 0, 8'h00, 0);
      add(8'h75, 1, 8'h75, 1, 1, 8'h00, 0);
      add(8'hE0, 0, 8'h00, 0, 0, 8'h00, 0);
      add(8'h12, 1, 8'h12, 0, 1, 8'h00, 0);
      add(8'h59, 1, 8'h59, 0, 0, 8'h00, 1);
      add(8'h2B, 1, 8'h2B, 0, 0, 8'h46, 1);
      add(8'hF0, 0, 8'h00, 0, 0, 8'h00, 1);
      add(8'h59, 1, 8'h59, 1, 0, 8'h00, 0);
      add(8'hAA, 0, 8'h00, 0, 0, 8'h00, 0);
      add(8'hFA, 0, 8'h00, 0, 0, 8'h00, 0);
      add(8'hEE, 0, 8'h00, 0, 0, 8'h00, 0);
      add(8'h5A, 1, 8'h5A, 0, 0, 8'h0D, 0);
      add(8'h29, 1, 8'h29, 0, 0, 8'h20, 0);
      add(8'h66, 1, 8'h66, 0, 0, 8'h08, 0);
      add(8'h45, 1, 8'h45, 0, 0, 8'h30, 0);
      add(8'h3D, 1, 8'h3D, 0, 0, 8'h37, 0);
      add(8'hF0, 0, 8'h00, 0, 0, 8'h00, 0);
      add(8'h16, 1, 8'h16, 1, 0, 8'h31, 0);
      add(8'hE0, 0, 8'h00, 0, 0, 8'h00, 0);
      add(8'hE0, 0, 8'h00, 0, 0, 8'h00, 0);
      add(8'h1C, 1, 8'h1C, 0, 1, 8'h00, 0);

      // Reset state
      #12;
      check("reset_outputs",
            32'({bus.oValid, bus.oKeyCode, bus.oBreak, bus.oExtended, bus.oAscii,
                 bus.oShift, bus.oError, bus.oOverflow}), 32'd0);
      @(negedge Clock);
      Reset = 1'b1;

      foreach (tbl[i]) begin
         if (tbl[i].ev) expect_ev(tbl[i].code, tbl[i].brk, tbl[i].ext, tbl[i].asc);
         strobe(tbl[i].d, 1'b0);
         check($sformatf("shift_v%0d", i), 32'(bus.oShift), 32'(tbl[i].sh));
         check($sformatf("valid_v%0d", i), 32'(bus.oValid), 32'(tbl[i].ev));
         drain();
      end

      // Read on empty is ignored
      bus.iRead = 1'b1;
      @(negedge Clock);
      bus.iRead = 1'b0;
      check("read_empty", 32'(bus.oValid), 32'd0);

      // Prefix protocol error: F0 then E0
      strobe(8'hF0, 1'b0);
      check("no_err_f0", 32'(bus.oError), 32'd0);
      strobe(8'hE0, 1'b0);
      check("err_pulse", 32'(bus.oError), 32'd1);
      check("err_no_event", 32'(bus.oValid), 32'd0);
      @(negedge Clock);
      check("err_one_cycle", 32'(bus.oError), 32'd0);
      expect_ev(8'h26, 0, 0, 8'h33);
      strobe(8'h26, 1'b0);
      drain();

      // Overflow: five makes into a 4-deep FIFO
      expect_ev(8'h16, 0, 0, 8'h31);
      expect_ev(8'h1E, 0, 0, 8'h32);
      expect_ev(8'h26, 0, 0, 8'h33);
      expect_ev(8'h25, 0, 0, 8'h34);
      strobe(8'h16, 1'b0);
      strobe(8'h1E, 1'b0);
      strobe(8'h26, 1'b0);
      strobe(8'h25, 1'b0);
      check("no_ovf_at_full", 32'(bus.oOverflow), 32'd0);
      strobe(8'h2E, 1'b0);
      check("ovf_set", 32'(bus.oOverflow), 32'd1);
      check("head_kept", 32'(bus.oKeyCode), 32'h16);
      // Simultaneous write and pop on a full FIFO
      strobe(8'h36, 1'b1);
      void'(exp_q.pop_front());
      expect_ev(8'h36, 0, 0, 8'h36);
      check("head_advanced", 32'(bus.oKeyCode), 32'h1E);
      drain();
      check("ovf_sticky", 32'(bus.oOverflow), 32'd1);

      // Reset mid-sequence discards buffered events, shift and the pending prefix
      strobe(8'h12, 1'b0);
      strobe(8'h16, 1'b0);
      strobe(8'hE0, 1'b0);
      #2;
      Reset = 1'b0;
      #1;
      check("async_reset_outputs",
            32'({bus.oValid, bus.oKeyCode, bus.oBreak, bus.oExtended, bus.oAscii,
                 bus.oShift, bus.oError, bus.oOverflow}), 32'd0);
      exp_q.delete();
      @(negedge Clock);
      Reset = 1'b1;
      expect_ev(8'h45, 0, 0, 8'h30);
      strobe(8'h45, 1'b0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
